// File: rtl/switch_reader.sv
// switch_reader: synchronises and debounces the raw board switch vector and
// publishes the stable value plus rising/falling change masks over a
// valid/ready handshake. Events the consumer has not yet taken are merged.
module switch_reader #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_rise,
  output logic [WIDTH-1:0] evt_fall,
  output logic             evt_merged,
  output logic [15:0]      evt_count
);

  // Counter wide enough to reach DEBOUNCE_CYCLES-1; one bit minimum so a
  // debounce length of 1 still has a legal register.
  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;
  logic             commit;
  logic             xfer;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // A commit happens once the candidate has survived the full count and
  // actually differs from what is already published.
  always_comb begin
    commit = (s2 == cand) && (cnt == CNT_MAX) && (cand != sw_stable);
    rise   = cand & ~sw_stable;
    fall   = ~cand & sw_stable;
    xfer   = evt_valid && evt_ready;
  end

  // Two-flop synchroniser; only s2 is trusted downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // One shared stability counter: any change anywhere in the vector restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt  <= cnt + CW'(1);
    end
  end

  // Publish the debounced value and count every commit (wraps naturally).
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_stable <= '0;
      evt_count <= '0;
    end else if (commit) begin
      sw_stable <= cand;
      evt_count <= evt_count + 16'd1;
    end
  end

  // Event holding register: fresh load when empty or draining this cycle,
  // otherwise OR new edges into the held event so nothing is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid  <= 1'b0;
      evt_rise   <= '0;
      evt_fall   <= '0;
      evt_merged <= 1'b0;
    end else if (commit) begin
      evt_valid <= 1'b1;
      if (!evt_valid || xfer) begin
        evt_rise   <= rise;
        evt_fall   <= fall;
        evt_merged <= 1'b0;
      end else begin
        evt_rise   <= evt_rise | rise;
        evt_fall   <= evt_fall | fall;
        evt_merged <= 1'b1;
      end
    end else if (xfer) begin
      evt_valid  <= 1'b0;
      evt_rise   <= '0;
      evt_fall   <= '0;
      evt_merged <= 1'b0;
    end
  end

endmodule

// File: doc/switch_reader.md
Name: switch_reader

Overview:
- Input-side counterpart of the board's LED output drivers.
- Samples the 16 raw board switches/buttons, synchronises them and debounces the whole vector.
- Publishes a stable switch value and change events (rising/falling bit masks) over a valid/ready handshake to downstream control logic.
- Pending events that the consumer has not yet taken are merged, never dropped.

Parameters:
- WIDTH, 16, number of switch inputs.
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised vector must hold before commit; legal range ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  WIDTH  asynchronous raw switch levels.
- sw_stable  output  WIDTH  debounced switch value.
- evt_valid  output  1  change event pending.
- evt_ready  input  1  consumer accepts event when high with evt_valid.
- evt_rise  output  WIDTH  bits that went 0→1 since last accepted event.
- evt_fall  output  WIDTH  bits that went 1→0 since last accepted event.
- evt_merged  output  1  more than one commit folded into the current event.
- evt_count  output  16  total commits since reset; wraps 0xFFFF→0.

Behaviour:
- Reset:
  - The design has one clock; reset is synchronous and active-high.
  - Reset clears both synchroniser stages, the candidate register, the stability counter, sw_stable, evt_valid, evt_rise, evt_fall, evt_merged and evt_count.
  - Reset asserted mid-bounce or with an event pending discards everything; no event is emitted for the reset itself.
- Synchroniser: sw_raw → s1 → s2 on successive edges. s2 is the only value used downstream.
- Debounce (single shared counter over the whole vector):
  - s2 != cand: cand <= s2, cnt <= 0.
  - s2 == cand and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 == cand and cnt == DEBOUNCE_CYCLES-1: cnt holds (saturates). If cand != sw_stable, this is a commit.
- Commit:
  - sw_stable <= cand.
  - rise = cand & ~sw_stable; fall = ~cand & sw_stable.
  - evt_count <= evt_count+1.
- Latency: raw change held steady from before edge 1 → s1 at edge 1, s2 at edge 2, cand loaded at edge 3, commit at edge DEBOUNCE_CYCLES+3. With the default of 4, sw_stable updates 7 cycles after the change.
- Glitches: any s2 change before the count completes restarts the count. A glitch that returns to the sw_stable value produces no commit and no event.
- Event handshake:
  - Transfer occurs on a cycle where evt_valid && evt_ready.
  - evt_rise, evt_fall and evt_merged are stable while evt_valid=1 and evt_ready=0.
  - Commit, no event held (evt_valid=0): load rise and fall, evt_merged=0, evt_valid=1 on the next cycle.
  - Commit while an event is held and not transferring: evt_rise |= rise, evt_fall |= fall, evt_merged <= 1, evt_valid stays 1. A bit toggled twice shows in both evt_rise and evt_fall.
  - Commit in the same cycle as a transfer: load the new rise and fall only, evt_merged=0, evt_valid stays 1.
  - Transfer with no commit: evt_valid <= 0; evt_rise, evt_fall and evt_merged clear to 0.
- evt_ready while evt_valid=0 is ignored.
- Pending events are never dropped. Merging is the only loss of temporal detail.

Test Plan:
- Reset then idle, sw_raw=0x0000 → sw_stable=0x0000, evt_valid=0 and evt_count=0 for 50 cycles.
- Clean edge: sw_raw 0x0000→0x0005 held, evt_ready=1, default parameters → sw_stable=0x0005 exactly 7 cycles after the change. evt_valid pulses 1 cycle with evt_rise=0x0005, evt_fall=0x0000, evt_merged=0. evt_count=1.
- Bounce: sw_raw toggles bit 0 every 2 cycles for 20 cycles, then settles at 0x0001 → exactly one commit, 7 cycles after settling. evt_rise=0x0001, evt_count=1.
- Glitch rejection: from stable 0x0000, sw_raw=0x0100 for 3 cycles, then back to 0x0000 → no change to sw_stable, no event.
- Backpressure merge, evt_ready=0:
  - Step 1: 0x0000→0x0001 → event held with evt_rise=0x0001.
  - Step 2: then →0x0000 → evt_fall=0x0001, evt_merged=1, evt_count=2.
  - Step 3: raise evt_ready for 1 cycle → evt_valid drops and outputs clear.
  - Step 4: commit coincident with transfer → new event loaded, evt_merged=0, evt_valid stays 1.
- Reset mid-operation: event pending and a new change 2 cycles into the count, assert rst 1 cycle → all outputs 0 next cycle. sw_raw still 0x0003 yields a fresh commit 7 cycles after rst deasserts, with evt_rise=0x0003 and evt_count=1.
